// File: rtl/dithering_pkg.sv
// Shared types and default geometry for the dithering frame scheduler.
package dithering_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_PIX,
        ADVANCE,
        DONE
    } sched_state_t;

    localparam int unsigned DEF_IMG_W   = 320;
    localparam int unsigned DEF_IMG_H   = 240;
    localparam int unsigned DEF_PIX_LAT = 4;

endpackage

// File: rtl/dithering_coord_counter.sv
// Raster-order x/y/linear-address counter; addr tracks y*IMG_W+x by incrementing.
module dithering_coord_counter
    import dithering_pkg::*;
#(
    parameter int unsigned IMG_W = DEF_IMG_W,
    parameter int unsigned IMG_H = DEF_IMG_H,
    parameter int unsigned XW    = $clog2(IMG_W),
    parameter int unsigned YW    = $clog2(IMG_H),
    parameter int unsigned AW    = $clog2(IMG_W * IMG_H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          advance,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [AW-1:0] addr,
    output logic          last
);

    logic x_last;
    logic y_last;

    assign x_last = (x == XW'(IMG_W - 1));
    assign y_last = (y == YW'(IMG_H - 1));
    assign last   = x_last && y_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (clear) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (advance) begin
            // Advancing past the final pixel wraps everything to zero.
            if (x_last) begin
                x <= '0;
                y <= y_last ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
            addr <= last ? '0 : addr + 1'b1;
        end
    end

endmodule

// File: rtl/dithering_frame_scheduler.sv
// Walks an IMG_W x IMG_H frame in raster order, pulsing the per-pixel engine once per pixel.
module dithering_frame_scheduler
    import dithering_pkg::*;
#(
    parameter int unsigned IMG_W   = DEF_IMG_W,
    parameter int unsigned IMG_H   = DEF_IMG_H,
    parameter int unsigned PIX_LAT = DEF_PIX_LAT,
    localparam int unsigned XW     = $clog2(IMG_W),
    localparam int unsigned YW     = $clog2(IMG_H),
    localparam int unsigned AW     = $clog2(IMG_W * IMG_H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          mem_ready,
    output logic          algorithm_trigger,
    output logic [XW-1:0] pixel_x,
    output logic [YW-1:0] pixel_y,
    output logic [AW-1:0] pixel_addr,
    output logic          err_right_en,
    output logic          err_down_en,
    output logic          err_downleft_en,
    output logic          err_downright_en,
    output logic          busy,
    output logic          frame_done
);

    localparam int unsigned CW = $clog2(PIX_LAT);

    sched_state_t  state;
    logic [CW-1:0] wait_cnt;
    logic          coord_clear;
    logic          coord_advance;
    logic          coord_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (state != IDLE && abort) begin
                state    <= IDLE;
                wait_cnt <= '0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        wait_cnt <= '0;
                        if (start && !abort) begin
                            state <= ISSUE;
                            busy  <= 1'b1;
                        end
                    end
                    ISSUE: begin
                        if (mem_ready) begin
                            wait_cnt <= CW'(PIX_LAT - 1);
                            state    <= WAIT_PIX;
                        end
                    end
                    WAIT_PIX: begin
                        if (wait_cnt == '0) begin
                            state <= ADVANCE;
                        end else begin
                            wait_cnt <= wait_cnt - 1'b1;
                        end
                    end
                    ADVANCE: begin
                        if (coord_last) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

    // The trigger must fire in the same cycle mem_ready is seen, so it is decoded, not registered.
    assign algorithm_trigger = (state == ISSUE) && mem_ready && !abort;

    assign coord_clear   = ((state != IDLE) && abort) || (state == DONE);
    assign coord_advance = (state == ADVANCE) && !abort && !coord_last;

    dithering_coord_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .XW    (XW),
        .YW    (YW),
        .AW    (AW)
    ) u_coord (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (coord_clear),
        .advance (coord_advance),
        .x       (pixel_x),
        .y       (pixel_y),
        .addr    (pixel_addr),
        .last    (coord_last)
    );

    logic x_first;
    logic x_last;
    logic y_last;

    assign x_first = (pixel_x == '0);
    assign x_last  = (pixel_x == XW'(IMG_W - 1));
    assign y_last  = (pixel_y == YW'(IMG_H - 1));

    assign err_right_en     = busy && !x_last;
    assign err_down_en      = busy && !y_last;
    assign err_downleft_en  = busy && !y_last && !x_first;
    assign err_downright_en = busy && !y_last && !x_last;

endmodule

// File: tb/tb_dithering_frame_scheduler.sv
// Directed bench for a 4x2 frame with PIX_LAT=4: trigger cadence, stalls, abort and reset.
module tb_dithering_frame_scheduler;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       mem_ready;
    logic       algorithm_trigger;
    logic [1:0] pixel_x;
    logic [0:0] pixel_y;
    logic [2:0] pixel_addr;
    logic       err_right_en;
    logic       err_down_en;
    logic       err_downleft_en;
    logic       err_downright_en;
    logic       busy;
    logic       frame_done;

    int vectors;
    int miscompares;

    // {right, down, downleft, downright} for pixels 0..7
    logic [3:0] exp_edge [8] = '{4'b1101, 4'b1111, 4'b1111, 4'b0110,
                                 4'b1000, 4'b1000, 4'b1000, 4'b0000};

    dithering_frame_scheduler #(
        .IMG_W   (4),
        .IMG_H   (2),
        .PIX_LAT (4)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .abort             (abort),
        .mem_ready         (mem_ready),
        .algorithm_trigger (algorithm_trigger),
        .pixel_x           (pixel_x),
        .pixel_y           (pixel_y),
        .pixel_addr        (pixel_addr),
        .err_right_en      (err_right_en),
        .err_down_en       (err_down_en),
        .err_downleft_en   (err_downleft_en),
        .err_downright_en  (err_downright_en),
        .busy              (busy),
        .frame_done        (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] edges();
        return {28'd0, err_right_en, err_down_en, err_downleft_en, err_downright_en};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_trig"}, algorithm_trigger, 0);
        chk({tag, "_done"}, frame_done, 0);
        chk({tag, "_x"}, pixel_x, 0);
        chk({tag, "_y"}, pixel_y, 0);
        chk({tag, "_addr"}, pixel_addr, 0);
        chk({tag, "_edges"}, edges(), 0);
    endtask

    // Entered 1 time unit after an edge (cycle 0); start is driven high for that cycle.
    task automatic run_frame(input int stall_len, input int start_hold, input string nm);
        int done_cyc;
        int k;
        int t_k;
        logic exp_trig;
        done_cyc  = 49 + stall_len;
        k         = 0;
        start     = 1'b1;
        abort     = 1'b0;
        mem_ready = 1'b1;
        #3;
        chk({nm, "_c0_busy"}, busy, 0);
        for (int c = 1; c <= done_cyc + 2; c++) begin
            step();
            start     = (c < start_hold);
            mem_ready = !(stall_len > 0 && c >= 13 && c < 13 + stall_len);
            #3;
            t_k      = (k < 2) ? 1 + 6 * k : 13 + stall_len + 6 * (k - 2);
            exp_trig = (k < 8) && (c == t_k);
            chk($sformatf("%s_trig_c%0d", nm, c), algorithm_trigger, exp_trig);
            chk($sformatf("%s_busy_c%0d", nm, c), busy, (c <= done_cyc));
            chk($sformatf("%s_done_c%0d", nm, c), frame_done, (c == done_cyc));
            if (!mem_ready) begin
                chk($sformatf("%s_stall_x_c%0d", nm, c), pixel_x, 2);
            end
            if (exp_trig) begin
                chk($sformatf("%s_x_p%0d", nm, k), pixel_x, k % 4);
                chk($sformatf("%s_y_p%0d", nm, k), pixel_y, k / 4);
                chk($sformatf("%s_addr_p%0d", nm, k), pixel_addr, k);
                chk($sformatf("%s_edges_p%0d", nm, k), edges(), exp_edge[k]);
                k++;
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        mem_ready   = 1'b0;
        #2;
        chk_quiet("reset");

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        // Start held through cycle 29: re-asserting start while busy must not restart.
        run_frame(0, 30, "frame");

        step();
        run_frame(5, 1, "stall");

        // Abort at cycle 20 while in WAIT_PIX of pixel 3
        step();
        start = 1'b1;
        mem_ready = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step();
            start = 1'b0;
            abort = (c == 20);
        end
        #3;
        chk("abort_c20_busy", busy, 1);
        chk("abort_c20_x", pixel_x, 3);
        step();
        abort = 1'b0;
        #3;
        chk_quiet("abort_c21");
        for (int c = 22; c <= 30; c++) begin
            step();
            #3;
            chk($sformatf("abort_nodone_c%0d", c), frame_done, 0);
            chk($sformatf("abort_idle_c%0d", c), busy, 0);
        end
        step();
        run_frame(0, 1, "restart");

        // Abort during the ISSUE of pixel 1 suppresses that trigger
        step();
        start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            start = 1'b0;
            abort = (c == 7);
        end
        #3;
        chk("abort_issue_trig", algorithm_trigger, 0);
        chk("abort_issue_x", pixel_x, 1);
        step();
        abort = 1'b0;
        #3;
        chk_quiet("abort_issue_after");

        // Abort wins over start when both arrive in IDLE
        step();
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        #3;
        chk("abort_beats_start_busy", busy, 0);
        step();
        #3;
        chk("abort_beats_start_idle", busy, 0);

        // Reset asserted at cycle 15 mid-frame
        step();
        start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            step();
            #3;
            if (c == 10) begin
                chk("busy_start_ignored_x", pixel_x, 1);
            end
        end
        chk("rst_pre_x", pixel_x, 2);
        chk("rst_pre_busy", busy, 1);
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_quiet("rst_mid");
        step();
        #3;
        chk("rst_hold_done", frame_done, 0);
        step();
        rst_n = 1'b1;
        step();
        run_frame(0, 1, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dithering_frame_scheduler.md
DITHERING_FRAME_SCHEDULER -- requirements
Module: dithering_frame_scheduler

Interface
REQ-001 SHALL have parameter IMG_W, default 320, image width in pixels (≥2).
REQ-002 SHALL have parameter IMG_H, default 240, image height in pixels (≥2).
REQ-003 SHALL have parameter PIX_LAT, default 4, wait cycles per pixel after trigger (≥4, covers the per-pixel engine's STORE/COMPARE/FINAL/return-to-WAIT sequence).
REQ-004 SHALL derive XW=$clog2(IMG_W), YW=$clog2(IMG_H), AW=$clog2(IMG_W*IMG_H).
REQ-005 SHALL have ports: one clock; reset asynchronous, active-low:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level; begin frame when idle
- abort  in  1  level; cancel frame
- mem_ready  in  1  pixel/error memory may accept a new pixel
- algorithm_trigger  out  1  one-cycle pulse to per-pixel dithering loop control
- pixel_x  out  XW  current column
- pixel_y  out  YW  current row
- pixel_addr  out  AW  linear index y*IMG_W+x
- err_right_en, err_down_en, err_downleft_en, err_downright_en  out  1 each  error-diffusion neighbour valid
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle completion pulse

Function
REQ-006 SHALL implement states IDLE, ISSUE, WAIT_PIX, ADVANCE, DONE.
REQ-007 IDLE: busy=0; start=1 and abort=0 -> ISSUE with x=y=addr=0; start ignored outside IDLE.
REQ-008 ISSUE: mem_ready=1 -> algorithm_trigger=1 this cycle, load wait counter PIX_LAT-1, -> WAIT_PIX; mem_ready=0 -> stay, trigger=0, coordinates held.
REQ-009 WAIT_PIX: counter decrements each cycle; at 0 -> ADVANCE (exactly PIX_LAT cycles in WAIT_PIX).
REQ-010 ADVANCE: x=IMG_W-1 and y=IMG_H-1 -> DONE; x=IMG_W-1 -> x=0, y+1; else x+1; addr+1 in both non-final cases; non-final -> ISSUE.
REQ-011 DONE: frame_done=1 for one cycle, -> IDLE, x=y=addr cleared.
REQ-012 Per-pixel period SHALL be PIX_LAT+2 cycles with mem_ready held high; algorithm_trigger never asserted two cycles in a row.
REQ-013 abort=1 in any non-IDLE state -> IDLE next cycle, coordinates cleared, no frame_done; abort in ISSUE suppresses that cycle's trigger; abort beats start.
REQ-014 busy=1 in ISSUE, WAIT_PIX, ADVANCE, DONE.
REQ-015 Edge enables combinational from x,y, forced 0 when busy=0: right = x≠IMG_W-1; down = y≠IMG_H-1; downleft = down and x≠0; downright = down and x≠IMG_W-1.
REQ-016 pixel_addr SHALL be an incrementing counter (no multiplier), equal to y*IMG_W+x at all times.
REQ-017 No counter SHALL exceed IMG_W-1, IMG_H-1, IMG_W*IMG_H-1.

Reset
REQ-018 rst_n low SHALL asynchronously force IDLE, all outputs 0, wait counter 0; mid-frame reset abandons frame without frame_done.
REQ-019 After rst_n deassert, first start SHALL be accepted on the first rising edge it is sampled high.

Structure
REQ-020 Shared package dithering_pkg SHALL hold sched_state_t enum and default IMG_W/IMG_H/PIX_LAT constants.
REQ-021 x/y/addr wrap logic SHALL be one sub-module dithering_coord_counter (inputs clear, advance; outputs x, y, addr, last).

Verification (IMG_W=4, IMG_H=2, PIX_LAT=4)
REQ-022 start pulse at cycle 0, mem_ready=1 -> triggers at cycles 1,7,...,43 (8 total), frame_done at cycle 49, busy 1..49.
REQ-023 Edges: at (0,0) right=1,down=1,dl=0,dr=1; at (3,0) right=0,dr=0,dl=1; at (x,1) down=dl=dr=0; addr 0..7 in order.
REQ-024 mem_ready=0 for 5 cycles during pixel 2 ISSUE -> trigger delayed 5 cycles, frame_done at cycle 54.
REQ-025 abort at cycle 20 -> IDLE at 21, outputs 0, no frame_done; restart completes full frame from (0,0).
REQ-026 rst_n low at cycle 15 -> immediate outputs 0; start during busy ignored (no restart, x unchanged).
